// File: rtl/div_ctrl.sv
// div_ctrl: execute-stage sequencer for the shared iterative unsigned divider.
// Ports: req_* accept side, resp_* result side, div_* divider start/done, flush, busy.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              busy,
  output logic              div_valid,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic              div_done,
  input  logic [2*XLEN-1:0] div_c
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPT, RESP, DRAIN
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  logic            accept;
  logic            sgn, sa, sb, ovf;
  logic [XLEN-1:0] sel;
  logic            neg;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    // op[0] marks the unsigned variants, op[1] selects remainder
    accept  = req_valid && (state_q == IDLE) && !flush;
    sgn     = !req_op[0];
    sa      = sgn & req_a[XLEN-1];
    sb      = sgn & req_b[XLEN-1];
    ovf     = sgn && (req_a == MIN_NEG) && (req_b == '1);
    sel     = rem_q ? div_c[2*XLEN-1:XLEN] : div_c[XLEN-1:0];
    neg     = rem_q ? negr_q : negq_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d  = req_op[1];
          negq_d = sa ^ sb;
          negr_d = sa;
          if (req_b == '0) begin
            res_d   = req_op[1] ? req_a : '1;
            state_d = RESP;
          end else if (ovf) begin
            res_d   = req_op[1] ? '0 : MIN_NEG;
            state_d = RESP;
          end else begin
            a_d     = sa ? (~req_a + ONE) : req_a;
            b_d     = sb ? (~req_b + ONE) : req_b;
            state_d = ISSUE;
          end
        end
      end
      // the start pulse already left this cycle, so a flush must drain it
      ISSUE: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          state_d = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          state_d = CAPT;
        end
      end
      // div_c is only valid one edge after div_done
      CAPT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          res_d   = neg ? (~sel + ONE) : sel;
          state_d = RESP;
        end
      end
      RESP: if (flush || resp_ready) state_d = IDLE;
      DRAIN: if (div_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign div_valid  = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = res_q;
  assign div_a      = a_q;
  assign div_b      = b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a behavioural divider stub.
// Expected results go through a scoreboard queue popped at each response.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic        div_valid;
  logic [31:0] div_a, div_b;
  logic        div_done;
  logic [63:0] div_c;

  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  int          lat = 3;
  int          cnt;
  logic [31:0] a_cap, b_cap;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy),
    .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_c(div_c)
  );

  // divider stub: result register updates on the edge that ends the done cycle
  always @(posedge clk) begin
    if (reset) begin
      cnt      <= 0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_valid) begin
        cnt    <= lat;
        a_cap  <= div_a;
        b_cap  <= div_b;
        pulses <= pulses + 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) div_done <= 1'b1;
      end
      if (div_done) div_c <= {a_cap % b_cap, a_cap / b_cap};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [31:0] ma,
                       input logic [31:0] mb, input bit special,
                       input int hold);
    int n, dcyc, p0;
    bit stab, hstab;
    logic [31:0] e;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = (hold == 0);
    sb.push_back(exp);
    p0 = pulses;
    @(negedge clk);
    req_valid = 1'b0;
    if (special)
      chk({tag, "_lat1"}, {31'b0, resp_valid}, 32'd1);
    else
      chk({tag, "_start"}, {31'b0, div_valid}, 32'd1);
    n = 0;
    dcyc = -100;
    stab = 1'b1;
    while (!resp_valid && n < 200) begin
      if (div_done) dcyc = n;
      if (div_a !== ma || div_b !== mb) stab = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, {31'b0, resp_valid}, 32'd1);
    if (!special) begin
      chk({tag, "_lat"}, n - dcyc, 32'd2);
      chk({tag, "_opstable"}, {31'b0, stab}, 32'd1);
      chk({tag, "_diva"}, a_cap, ma);
      chk({tag, "_divb"}, b_cap, mb);
    end
    chk({tag, "_pulses"}, pulses - p0, special ? 32'd0 : 32'd1);
    hstab = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid || resp_data !== exp || req_ready) hstab = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk({tag, "_hold"}, {31'b0, hstab}, 32'd1);
    resp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sbempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, resp_data, e);
    end
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    div_c      = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'b0, req_ready, resp_valid, busy, div_valid, 2'b0},
        32'h20);
    chk("rst_diva", div_a, 32'd0);
    chk("rst_divb", div_b, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    reset = 1'b0;

    do_op("divu", 2'b01, 100, 7, 14, 100, 7, 0, 0);
    do_op("remu", 2'b11, 100, 7, 2, 100, 7, 0, 0);
    do_op("div_m7_2", 2'b00, -32'sd7, 2, 32'hFFFFFFFD, 7, 2, 0, 0);
    do_op("rem_m7_2", 2'b10, -32'sd7, 2, 32'hFFFFFFFF, 7, 2, 0, 0);
    do_op("div_7_m2", 2'b00, 7, -32'sd2, 32'hFFFFFFFD, 7, 2, 0, 0);
    do_op("rem_7_m2", 2'b10, 7, -32'sd2, 32'd1, 7, 2, 0, 0);
    do_op("div_min_2", 2'b00, 32'h80000000, 2, 32'hC0000000,
          32'h80000000, 2, 0, 0);
    do_op("divu_min_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,
          32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_op("div_by0", 2'b00, 5, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    do_op("rem_by0", 2'b10, 5, 0, 32'd5, 0, 0, 1, 0);
    do_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
          0, 0, 1, 0);
    do_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, 1, 0);
    do_op("backpr", 2'b01, 9, 3, 32'd3, 9, 3, 0, 10);

    // request with flush in IDLE is not taken
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 50; req_b = 5; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush", {29'b0, req_ready, div_valid, resp_valid}, 32'h4);

    // flush during WAIT drains the divider silently
    lat = 18;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 77; req_b = 7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_busy", {30'b0, busy, req_ready}, 32'h2);
    n = 0;
    seen = 1'b0;
    while (!div_done && n < 100) begin
      if (resp_valid || req_ready) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("drain_done_seen", {31'b0, div_done}, 32'd1);
    chk("drain_quiet", {31'b0, seen}, 32'd0);
    @(negedge clk);
    chk("drain_idle", {30'b0, req_ready, resp_valid}, 32'h2);
    lat = 3;
    do_op("after_drain", 2'b01, 8, 2, 32'd4, 8, 2, 0, 0);

    // flush beats resp_ready in RESP
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 5; req_b = 0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("fresp_valid", {31'b0, resp_valid}, 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fresp_idle", {30'b0, req_ready, resp_valid}, 32'h2);

    // reset mid-operation
    lat = 18;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 99; req_b = 9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait", {29'b0, req_ready, resp_valid, div_valid}, 32'h4);
    lat = 3;
    do_op("after_rst", 2'b11, 10, 4, 32'd2, 10, 4, 0, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
